// File: rtl/dpi_flow_ctx_feeder_if.sv
// Bundle of the packet stream, context-clear, matcher and match-report
// signals around the DFA context feeder.
interface dpi_flow_ctx_feeder_if #(
    parameter int STATE_W = 11,
    parameter int FLOW_W  = 4,
    parameter int OFS_W   = 16
);
    // packet byte stream
    logic              pkt_vld;
    logic              pkt_rdy;
    logic [7:0]        pkt_data;
    logic              pkt_sop;
    logic              pkt_eop;
    logic [FLOW_W-1:0] pkt_flow;

    // context table maintenance
    logic              ctx_clr;
    logic [FLOW_W-1:0] ctx_clr_id;

    // DFA matcher side
    logic [7:0]         m_char;
    logic               m_char_vld;
    logic [STATE_W-1:0] m_state;
    logic               m_state_vld;
    logic [STATE_W-1:0] m_state_cur;
    logic               m_accept;

    // match events and framing errors
    logic              match_vld;
    logic [FLOW_W-1:0] match_flow;
    logic [OFS_W-1:0]  match_ofs;
    logic              proto_err;

    // environment side: packet source, table maintenance and matcher
    modport master (
        output pkt_vld, pkt_data, pkt_sop, pkt_eop, pkt_flow,
        output ctx_clr, ctx_clr_id,
        output m_state_cur, m_accept,
        input  pkt_rdy,
        input  m_char, m_char_vld, m_state, m_state_vld,
        input  match_vld, match_flow, match_ofs, proto_err
    );

    // feeder side
    modport slave (
        input  pkt_vld, pkt_data, pkt_sop, pkt_eop, pkt_flow,
        input  ctx_clr, ctx_clr_id,
        input  m_state_cur, m_accept,
        output pkt_rdy,
        output m_char, m_char_vld, m_state, m_state_vld,
        output match_vld, match_flow, match_ofs, proto_err
    );
endinterface

// File: rtl/dpi_flow_ctx_feeder.sv
// Per-flow context feeder for one DFA regex matcher. Restores the saved DFA
// state of a flow at packet start, streams the packet bytes into the matcher
// and saves the matcher state back at packet end, so patterns spanning
// packets of the same flow are still found.
module dpi_flow_ctx_feeder #(
    parameter int STATE_W = 11,
    parameter int FLOW_W  = 4,
    parameter int OFS_W   = 16
) (
    input logic                   clk,
    input logic                   rst,
    dpi_flow_ctx_feeder_if.slave  bus
);
    localparam int DEPTH = 1 << FLOW_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] SAVE   = 2'd3;

    logic [1:0]         state;
    logic [FLOW_W-1:0]  cur_flow;
    logic [OFS_W-1:0]   ofs;
    logic               kill;
    logic [STATE_W-1:0] ctx_tbl [DEPTH];

    logic rdy;
    logic accept;
    logic sop_break;

    // Handshake: IDLE swallows stray non-sop bytes, STREAM takes everything
    // except a new sop that shows up before the current packet ended.
    always_comb begin
        sop_break = (state == STREAM) && bus.pkt_vld && bus.pkt_sop && (ofs != '0);
        rdy       = 1'b0;
        case (state)
            IDLE:    rdy = bus.pkt_vld && !bus.pkt_sop;
            STREAM:  rdy = !sop_break;
            default: rdy = 1'b0;
        endcase
        accept = (state == STREAM) && bus.pkt_vld && rdy;
    end

    assign bus.pkt_rdy     = rdy;
    assign bus.m_char_vld  = accept;
    assign bus.m_char      = accept ? bus.pkt_data : 8'h00;
    // LOAD and STREAM are exclusive states, so the two matcher strobes never overlap
    assign bus.m_state_vld = (state == LOAD);
    assign bus.m_state     = (state == LOAD) ? ctx_tbl[cur_flow] : '0;

    // Packet FSM, byte offset, kill flag and registered event outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cur_flow       <= '0;
            ofs            <= '0;
            kill           <= 1'b0;
            bus.match_vld  <= 1'b0;
            bus.match_flow <= '0;
            bus.match_ofs  <= '0;
            bus.proto_err  <= 1'b0;
        end else begin
            bus.match_vld <= 1'b0;
            bus.proto_err <= 1'b0;
            // a clear of the active flow must also discard the in-flight context
            if (bus.ctx_clr && (state != IDLE) && (bus.ctx_clr_id == cur_flow))
                kill <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.pkt_vld) begin
                        if (bus.pkt_sop) begin
                            cur_flow <= bus.pkt_flow;
                            kill     <= 1'b0;
                            state    <= LOAD;
                        end else begin
                            bus.proto_err <= 1'b1;
                        end
                    end
                end
                LOAD: state <= STREAM;
                STREAM: begin
                    if (accept) begin
                        if (ofs != '1)
                            ofs <= ofs + OFS_W'(1);
                        if (bus.m_accept) begin
                            bus.match_vld  <= 1'b1;
                            bus.match_flow <= cur_flow;
                            bus.match_ofs  <= ofs;
                        end
                        if (bus.pkt_eop)
                            state <= SAVE;
                    end else if (sop_break) begin
                        // missing eop: close this packet, the held sop restarts from IDLE
                        bus.proto_err <= 1'b1;
                        state         <= SAVE;
                    end
                end
                default: begin
                    ofs   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Context table: SAVE writes the matcher state back, ctx_clr overrides it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                ctx_tbl[i] <= '0;
        end else begin
            if (state == SAVE)
                ctx_tbl[cur_flow] <= kill ? '0 : bus.m_state_cur;
            if (bus.ctx_clr)
                ctx_tbl[bus.ctx_clr_id] <= '0;
        end
    end
endmodule

// File: tb/tb_dpi_flow_ctx_feeder.sv
// Bench for dpi_flow_ctx_feeder: a "LIST x" DFA matcher model drives the
// matcher side; expectations come from per-flow byte history.
`timescale 1ns/1ps
module tb_dpi_flow_ctx_feeder;
    localparam int STATE_W = 11;
    localparam int FLOW_W  = 4;
    localparam int OFS_W   = 16;
    localparam int PLEN    = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dpi_flow_ctx_feeder_if #(.STATE_W(STATE_W), .FLOW_W(FLOW_W), .OFS_W(OFS_W)) bus();

    dpi_flow_ctx_feeder #(.STATE_W(STATE_W), .FLOW_W(FLOW_W), .OFS_W(OFS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef byte bq_t[$];
    typedef struct { int flow; int val; } ev_t;
    typedef struct {
        int          flow;
        logic [63:0] txt;
        int          len;
        bit          eop;
        int          exp_load;
        int          exp_nm;
        int          exp_ofs;
        int          exp_err;
    } vec_t;

    byte pat[PLEN] = '{"L", "I", "S", "T", " ", "x"};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    // length of the longest tail of q that is a prefix of the pattern
    function automatic int sfx_of(input bq_t q);
        bit hit;
        for (int k = PLEN; k > 0; k--) begin
            if (q.size() >= k) begin
                hit = 1'b1;
                for (int j = 0; j < k; j++)
                    if (q[q.size() - k + j] != pat[j]) hit = 1'b0;
                if (hit) return k;
            end
        end
        return 0;
    endfunction

    function automatic int dfa_next(input int s, input byte c);
        bq_t q;
        int  ss;
        ss = (s > PLEN) ? 0 : s;
        for (int i = 0; i < ss; i++) q.push_back(pat[i]);
        q.push_back(c);
        return sfx_of(q);
    endfunction

    function automatic bq_t mkq(input logic [63:0] t, input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(byte'(t[8*(n-1-i) +: 8]));
        return q;
    endfunction

    // ---------------- matcher model ----------------
    logic [STATE_W-1:0] mt_state;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  mt_state <= '0;
        else if (bus.m_state_vld) mt_state <= bus.m_state;
        else if (bus.m_char_vld)  mt_state <= STATE_W'(dfa_next(int'(mt_state), byte'(bus.m_char)));
    end
    assign bus.m_state_cur = mt_state;
    assign bus.m_accept    = bus.m_char_vld && (dfa_next(int'(mt_state), byte'(bus.m_char)) == PLEN);

    // ---------------- reference model ----------------
    bq_t hist[16];
    ev_t exp_load[$];
    ev_t exp_match[$];
    int  exp_err = 0;
    bit  pend_noeop = 1'b0;

    task automatic model_pkt(input int f, input bq_t b, input bit eop, input bit kill);
        ev_t e;
        if (pend_noeop) exp_err++;
        pend_noeop = !eop;
        e.flow = f; e.val = sfx_of(hist[f]);
        exp_load.push_back(e);
        foreach (b[i]) begin
            hist[f].push_back(b[i]);
            if (hist[f].size() > PLEN) void'(hist[f].pop_front());
            if (sfx_of(hist[f]) == PLEN) begin
                e.flow = f; e.val = i;
                exp_match.push_back(e);
            end
        end
        if (kill) hist[f].delete();
    endtask

    // ---------------- monitor ----------------
    int  v_loads, v_load_val, v_nm, v_mofs, v_mflow, v_err;
    int  n_err = 0;
    ev_t me;

    task automatic vreset();
        v_loads = 0; v_load_val = -1; v_nm = 0; v_mofs = -1; v_mflow = -1; v_err = 0;
    endtask

    always @(negedge clk) begin
        if (bus.m_state_vld || bus.m_char_vld)
            chk("strobe_excl", int'(bus.m_state_vld & bus.m_char_vld), 0);
        if (bus.m_state_vld) begin
            v_loads++;
            v_load_val = int'(bus.m_state);
            if (exp_load.size() == 0) begin
                total++; bad++;
                $display("FAIL load_unexpected state=%0d", v_load_val);
            end else begin
                me = exp_load.pop_front();
                chk("load_state", v_load_val, me.val);
            end
        end
        if (bus.match_vld) begin
            v_nm++;
            v_mofs  = int'(bus.match_ofs);
            v_mflow = int'(bus.match_flow);
            if (exp_match.size() == 0) begin
                total++; bad++;
                $display("FAIL match_unexpected flow=%0d ofs=%0d", v_mflow, v_mofs);
            end else begin
                me = exp_match.pop_front();
                chk("match_flow", v_mflow, me.flow);
                chk("match_ofs", v_mofs, me.val);
            end
        end
        if (bus.proto_err) begin
            n_err++;
            v_err++;
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input int f, input byte d, input bit sop, input bit eop);
        bit ok;
        ok = 1'b0;
        bus.pkt_vld = 1'b1; bus.pkt_data = d; bus.pkt_sop = sop; bus.pkt_eop = eop;
        bus.pkt_flow = FLOW_W'(f);
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = bus.pkt_rdy;
            @(posedge clk); #1;
        end
        bus.pkt_vld = 1'b0; bus.pkt_sop = 1'b0; bus.pkt_eop = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout flow=%0d byte=%0d", f, d);
        end
    endtask

    task automatic run_pkt(input int f, input bq_t b, input bit eop, input bit kill, input bit gaps);
        model_pkt(f, b, eop, kill);
        foreach (b[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            send_byte(f, b[i], i == 0, eop && (i == b.size() - 1));
        end
    endtask

    task automatic pulse_clr(input int id, input int dly);
        repeat (dly) @(posedge clk);
        #1;
        bus.ctx_clr = 1'b1; bus.ctx_clr_id = FLOW_W'(id);
        @(posedge clk); #1;
        bus.ctx_clr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs[10];
        ev_t  e;
        bq_t  rq;
        int   rf, rn, e0;
        bit   reop;
        int   ph[16];

        vecs[0] = '{2, "LIST x", 6, 1'b1, 0, 1, 5, 0};
        vecs[1] = '{3, "LI",     2, 1'b1, 0, 0, 0, 0};
        vecs[2] = '{3, "ST x",   4, 1'b1, 2, 1, 3, 0};
        vecs[3] = '{1, "LI",     2, 1'b1, 0, 0, 0, 0};
        vecs[4] = '{5, "ZZ",     2, 1'b1, 0, 0, 0, 0};
        vecs[5] = '{1, "ST x",   4, 1'b1, 2, 1, 3, 0};
        vecs[6] = '{2, "Q",      1, 1'b1, 6, 0, 0, 0};
        vecs[7] = '{5, "LIST x", 6, 1'b1, 0, 1, 5, 0};
        vecs[8] = '{4, "LIS",    3, 1'b0, 0, 0, 0, 0};
        vecs[9] = '{4, "T x",    3, 1'b1, 3, 1, 2, 1};
        foreach (ph[i]) ph[i] = 0;

        rst = 1'b1;
        bus.pkt_vld = 1'b0; bus.pkt_data = 8'h00; bus.pkt_sop = 1'b0; bus.pkt_eop = 1'b0;
        bus.pkt_flow = '0; bus.ctx_clr = 1'b0; bus.ctx_clr_id = '0;
        repeat (2) @(negedge clk);
        chk("rst_pkt_rdy",   int'(bus.pkt_rdy), 0);
        chk("rst_match_vld", int'(bus.match_vld), 0);
        chk("rst_match_ofs", int'(bus.match_ofs), 0);
        chk("rst_proto_err", int'(bus.proto_err), 0);
        chk("rst_state_vld", int'(bus.m_state_vld), 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        // directed vectors
        foreach (vecs[k]) begin
            vreset();
            run_pkt(vecs[k].flow, mkq(vecs[k].txt, vecs[k].len), vecs[k].eop, 1'b0, 1'b0);
            idle(4);
            chk($sformatf("v%0d_nloads", k), v_loads, 1);
            chk($sformatf("v%0d_load", k), v_load_val, vecs[k].exp_load);
            chk($sformatf("v%0d_nmatch", k), v_nm, vecs[k].exp_nm);
            if (vecs[k].exp_nm > 0) begin
                chk($sformatf("v%0d_mofs", k), v_mofs, vecs[k].exp_ofs);
                chk($sformatf("v%0d_mflow", k), v_mflow, vecs[k].flow);
            end
            chk($sformatf("v%0d_err", k), v_err, vecs[k].exp_err);
        end

        // ctx_clr of the active flow during STREAM
        fork
            run_pkt(3, mkq("LI", 2), 1'b1, 1'b1, 1'b0);
            pulse_clr(3, 3);
        join
        idle(3);
        vreset();
        run_pkt(3, mkq("ST x", 4), 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("clr_stream_load", v_load_val, 0);
        chk("clr_stream_nomatch", v_nm, 0);

        // ctx_clr during LOAD: restore uses pre-clear value, save is killed
        run_pkt(7, mkq("LIS", 3), 1'b1, 1'b0, 1'b0);
        idle(3);
        vreset();
        fork
            run_pkt(7, mkq("T x", 3), 1'b1, 1'b1, 1'b0);
            pulse_clr(7, 1);
        join
        idle(4);
        chk("clr_load_restore", v_load_val, 3);
        chk("clr_load_match_ofs", v_mofs, 2);
        vreset();
        run_pkt(7, mkq("A", 1), 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("clr_load_after", v_load_val, 0);

        // ctx_clr in the SAVE cycle of the same flow: clear wins
        run_pkt(8, mkq("LIS", 3), 1'b1, 1'b0, 1'b0);
        idle(3);
        fork
            run_pkt(8, mkq("LI", 2), 1'b1, 1'b1, 1'b0);
            pulse_clr(8, 4);
        join
        idle(3);
        vreset();
        run_pkt(8, mkq("A", 1), 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("clr_save_after", v_load_val, 0);

        // ctx_clr of an idle flow
        pulse_clr(5, 0);
        hist[5].delete();
        idle(2);
        vreset();
        run_pkt(5, mkq("A", 1), 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("clr_idle_after", v_load_val, 0);

        // randomized packets, bubbles and missing eops
        for (int p = 0; p < 60; p++) begin
            rf   = $urandom_range(0, 15);
            rn   = $urandom_range(1, 8);
            reop = (p == 59) || ($urandom_range(0, 4) != 0);
            rq.delete();
            for (int j = 0; j < rn; j++) begin
                rq.push_back(($urandom_range(0, 9) < 8) ? pat[ph[rf]] : byte'("Z"));
                ph[rf] = (ph[rf] + 1) % PLEN;
            end
            run_pkt(rf, rq, reop, 1'b0, 1'b1);
        end
        idle(5);

        // reset in the middle of a packet
        e.flow = 6; e.val = sfx_of(hist[6]);
        exp_load.push_back(e);
        send_byte(6, "L", 1'b1, 1'b0);
        send_byte(6, "I", 1'b0, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_pkt_rdy",   int'(bus.pkt_rdy), 0);
        chk("midrst_match_vld", int'(bus.match_vld), 0);
        chk("midrst_state_vld", int'(bus.m_state_vld), 0);
        chk("midrst_char_vld",  int'(bus.m_char_vld), 0);
        chk("midrst_proto_err", int'(bus.proto_err), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        foreach (hist[i]) hist[i].delete();
        pend_noeop = 1'b0;
        idle(2);
        for (int f = 0; f < 16; f++) begin
            vreset();
            run_pkt(f, mkq("Z", 1), 1'b1, 1'b0, 1'b0);
            idle(3);
            chk($sformatf("post_rst_tbl%0d", f), v_load_val, 0);
        end

        // stray non-sop bytes in IDLE
        e0 = n_err;
        send_byte(0, "Q", 1'b0, 1'b0);
        send_byte(0, "R", 1'b0, 1'b0);
        send_byte(0, "S", 1'b0, 1'b0);
        idle(2);
        chk("stray_err", n_err - e0, 3);
        exp_err += 3;

        // fresh packet after everything
        vreset();
        run_pkt(9, mkq("LIST x", 6), 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("final_nmatch", v_nm, 1);
        chk("final_mofs", v_mofs, 5);
        chk("final_mflow", v_mflow, 9);

        idle(5);
        chk("left_loads", exp_load.size(), 0);
        chk("left_matches", exp_match.size(), 0);
        chk("proto_err_total", n_err, exp_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
